// File: rtl/tile_line_scheduler.sv
// Line-prefetch controller: during scanline L it builds line L+1 in the idle half of a
// ping-pong line buffer (tile map + sprite ROM) while streaming line L to the VGA pixels.
//
// state      | meaning
// IDLE       | no fill in progress; waits for hcount==0 with a visible next line
// FETCH_TILE | tile-map address for column col is on tmap_addr
// WAIT_TILE  | tile code arrives and is captured into code_q
// STREAM     | pixels px=0..15 of the tile: ROM read (or background) per clk
// DRAIN      | final buffer write of the tile lands; next column or done
module tile_line_scheduler #(
   parameter int HTOTAL  = 1600,
   parameter int VTOTAL  = 525,
   parameter int VACTIVE = 480,
   parameter int COLS    = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        blank_n,
   input  logic [15:0] bg_rgb,
   output logic [10:0] tmap_addr,
   input  logic [3:0]  tmap_data,
   output logic [11:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic        busy,
   output logic        overrun,
   input  logic        overrun_clr
);
   localparam int LINE_PIX = COLS * 16;

   typedef enum logic [2:0] {IDLE, FETCH_TILE, WAIT_TILE, STREAM, DRAIN} state_t;
   state_t state_q, state_d;

   logic [8:0]  line_q, line_d;
   logic [5:0]  col_q, col_d;
   logic [3:0]  px_q, px_d;
   logic [3:0]  code_q, code_d;
   logic [10:0] tmap_addr_q, tmap_addr_d;
   logic [11:0] rom_addr_q, rom_addr_d;
   logic        overrun_q, overrun_d;
   logic        wr_en_q, wr_en_d;
   logic [9:0]  wr_addr_q, wr_addr_d;
   logic        wr_bank_q, wr_bank_d;
   logic        wr_bg_q, wr_bg_d;

   logic        line_start;
   logic [9:0]  next_line;
   logic        next_visible;

   assign line_start   = (hcount == 11'd0);
   assign next_line    = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
   assign next_visible = (next_line < 10'(VACTIVE));

   function automatic logic [10:0] tile_addr(input logic [4:0] row, input logic [5:0] col);
      return ({6'd0, row} * 11'(COLS)) + {5'd0, col};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      col_d       = col_q;
      px_d        = px_q;
      code_d      = code_q;
      tmap_addr_d = tmap_addr_q;
      rom_addr_d  = rom_addr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_bank_d   = wr_bank_q;
      wr_bg_d     = wr_bg_q;
      overrun_d   = overrun_clr ? 1'b0 : overrun_q;
      if (line_start && state_q != IDLE) overrun_d = 1'b1;

      if (line_start) begin
         // A fill still in flight here is abandoned; the new line starts this cycle.
         if (next_visible) begin
            state_d     = FETCH_TILE;
            line_d      = next_line[8:0];
            col_d       = 6'd0;
            tmap_addr_d = tile_addr(next_line[8:4], 6'd0);
         end else begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            FETCH_TILE: state_d = WAIT_TILE;
            WAIT_TILE: begin
               code_d  = tmap_data;
               px_d    = 4'd0;
               state_d = STREAM;
               if (tmap_data != 4'd0) rom_addr_d = {tmap_data, line_q[3:0], 4'd0};
            end
            STREAM: begin
               wr_en_d   = 1'b1;
               wr_addr_d = {col_q, px_q};
               wr_bank_d = line_q[0];
               wr_bg_d   = (code_q == 4'd0);
               if (px_q == 4'd15) begin
                  state_d = DRAIN;
               end else begin
                  px_d = px_q + 4'd1;
                  if (code_q != 4'd0) rom_addr_d = {code_q, line_q[3:0], px_q + 4'd1};
               end
            end
            DRAIN: begin
               if (col_q == 6'(COLS - 1)) begin
                  state_d = IDLE;
               end else begin
                  col_d       = col_q + 6'd1;
                  tmap_addr_d = tile_addr(line_q[8:4], col_q + 6'd1);
                  state_d     = FETCH_TILE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q      <= '0;
         col_q       <= '0;
         px_q        <= '0;
         code_q      <= '0;
         tmap_addr_q <= '0;
         rom_addr_q  <= '0;
         overrun_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_bank_q   <= 1'b0;
         wr_bg_q     <= 1'b0;
      end else begin
         line_q      <= line_d;
         col_q       <= col_d;
         px_q        <= px_d;
         code_q      <= code_d;
         tmap_addr_q <= tmap_addr_d;
         rom_addr_q  <= rom_addr_d;
         overrun_q   <= overrun_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_bank_q   <= wr_bank_d;
         wr_bg_q     <= wr_bg_d;
      end
   end

   // Ping-pong line buffer; line n lives in bank n[0], so fill and display never share a bank.
   logic [15:0] lbuf [2][LINE_PIX];
   logic [15:0] wr_data;
   logic [9:0]  rd_x;
   logic [9:0]  rd_idx;
   logic [15:0] rd_q;
   logic        blank_d1_q;
   logic [7:0]  pix_r_q, pix_g_q, pix_b_q;

   assign wr_data = wr_bg_q ? bg_rgb : rom_data;
   assign rd_x    = hcount[10:1];
   assign rd_idx  = (rd_x < 10'(LINE_PIX) && hcount < 11'(HTOTAL)) ? rd_x : 10'd0;

   always_ff @(posedge clk) begin
      if (wr_en_q) lbuf[wr_bank_q][wr_addr_q] <= wr_data;
      rd_q <= lbuf[vcount[0]][rd_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_d1_q <= 1'b0;
         pix_r_q    <= '0;
         pix_g_q    <= '0;
         pix_b_q    <= '0;
      end else begin
         blank_d1_q <= blank_n;
         if (blank_d1_q) begin
            pix_r_q <= {rd_q[15:11], 3'b000};
            pix_g_q <= {rd_q[10:5], 2'b00};
            pix_b_q <= {rd_q[4:0], 3'b000};
         end else begin
            pix_r_q <= '0;
            pix_g_q <= '0;
            pix_b_q <= '0;
         end
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      overrun   = overrun_q;
      tmap_addr = tmap_addr_q;
      rom_addr  = rom_addr_q;
      pix_r     = pix_r_q;
      pix_g     = pix_g_q;
      pix_b     = pix_b_q;
   end
endmodule

// File: tb/tb_tile_line_scheduler.sv
// Bench for tile_line_scheduler: drives VGA counters line by line, models tile map and ROM,
// and predicts line-buffer contents directly from tile codes, ROM words and bg colour.
module tb_tile_line_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        blank_n;
   logic [15:0] bg_rgb;
   logic [10:0] tmap_addr;
   logic [3:0]  tmap_data;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        busy, overrun, overrun_clr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  tmap [1200];
   logic [15:0] rom_salt;
   logic [15:0] exp_bank [2][640];
   int          bank_line [2];
   logic [7:0]  got_r [1600];
   logic [7:0]  got_g [1600];
   logic [7:0]  got_b [1600];
   logic        busy_at [1600];
   logic        ovr_at [1600];
   logic [10:0] tmap_at [1600];
   logic [11:0] rom_at [1600];
   int          prev_h, prev_v;
   logic        prev_blank, prev_ok;

   always #10 clk = ~clk;

   tile_line_scheduler dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
      .bg_rgb(bg_rgb), .tmap_addr(tmap_addr), .tmap_data(tmap_data), .rom_addr(rom_addr),
      .rom_data(rom_data), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .busy(busy),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   function automatic logic [15:0] rom_word(input logic [11:0] a);
      logic [31:0] t;
      t = {20'd0, a} * 32'h9E37 + {16'd0, rom_salt};
      return t[23:8];
   endfunction

   // Synchronous tile-map RAM and sprite ROM: data one clk after the address.
   always @(posedge clk) begin
      rom_data  <= rom_word(rom_addr);
      tmap_data <= (tmap_addr < 11'd1200) ? tmap[tmap_addr] : 4'd0;
   end

   function automatic logic [15:0] ref_pix(input int n, input int x);
      logic [3:0] code;
      code = tmap[(n / 16) * 40 + x / 16];
      if (code == 4'd0) return bg_rgb;
      return rom_word({code, 4'(n % 16), 4'(x % 16)});
   endfunction

   task automatic fill_tmap(input int mode);
      for (int i = 0; i < 1200; i++)
         tmap[i] = (mode < 0) ? 4'($urandom_range(0, 15)) : 4'(mode);
   endtask

   task automatic run_line(input int v, input int h0, input int htot, input bit chk,
                           input int clr_at);
      int n;
      logic [15:0] d;
      logic [7:0] er, eg, eb;
      n = (v == 524) ? 0 : v + 1;
      if (n < 480) begin
         if (h0 == 0 && htot >= 800) begin
            for (int x = 0; x < 640; x++) exp_bank[n % 2][x] = ref_pix(n, x);
            bank_line[n % 2] = n;
         end else begin
            bank_line[n % 2] = -1;
         end
      end
      for (int h = h0; h < htot; h++) begin
         hcount      = 11'(h);
         vcount      = 10'(v);
         blank_n     = (v < 480) && (h < 1280);
         overrun_clr = (h == clr_at);
         @(posedge clk);
         #1;
         got_r[h] = pix_r; got_g[h] = pix_g; got_b[h] = pix_b;
         busy_at[h] = busy; ovr_at[h] = overrun;
         tmap_at[h] = tmap_addr; rom_at[h] = rom_addr;
         if (chk && prev_ok && (!prev_blank || bank_line[prev_v % 2] == prev_v)) begin
            if (prev_blank) begin
               d  = exp_bank[prev_v % 2][prev_h / 2];
               er = {d[15:11], 3'b000}; eg = {d[10:5], 2'b00}; eb = {d[4:0], 3'b000};
            end else begin
               er = 8'd0; eg = 8'd0; eb = 8'd0;
            end
            n_tests++;
            if ({pix_r, pix_g, pix_b} !== {er, eg, eb}) begin
               n_fail++;
               $display("FAIL pixel line=%0d hcount=%0d got=%h_%h_%h expected=%h_%h_%h",
                        prev_v, prev_h, pix_r, pix_g, pix_b, er, eg, eb);
            end
         end
         prev_h = h; prev_v = v; prev_blank = blank_n; prev_ok = 1'b1;
      end
      overrun_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; hcount = 11'd1; vcount = 10'd0; blank_n = 1'b0;
      bg_rgb = 16'd0; overrun_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b expected=0", busy); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b expected=0", overrun); end
      n_tests++; if (tmap_addr !== 11'd0) begin n_fail++; $display("FAIL reset_tmap_addr got=%0d expected=0", tmap_addr); end
      n_tests++; if (rom_addr !== 12'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%h expected=0", rom_addr); end
      n_tests++; if ({pix_r, pix_g, pix_b} !== 24'd0) begin n_fail++; $display("FAIL reset_pix got=%h_%h_%h expected=0", pix_r, pix_g, pix_b); end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got=%b expected=0", busy); end
   endtask

   task automatic test_reset_mid_stream();
      int cnt;
      fill_tmap(3);
      run_line(9, 0, 141, 0, -1);
      hcount = 11'd141;
      #1;
      n_tests++; if (rom_addr !== 12'h3A5) begin n_fail++; $display("FAIL midstream_rom_addr got=%h expected=3a5", rom_addr); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midstream_busy got=%b expected=1", busy); end
      reset = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%b expected=0", busy); end
      n_tests++; if (rom_addr !== 12'd0) begin n_fail++; $display("FAIL async_reset_rom_addr got=%h expected=0", rom_addr); end
      n_tests++; if ({pix_r, pix_g, pix_b} !== 24'd0) begin n_fail++; $display("FAIL async_reset_pix got=%h_%h_%h expected=0", pix_r, pix_g, pix_b); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      prev_ok = 1'b0; bank_line[0] = -1; bank_line[1] = -1;
      run_line(9, 142, 1600, 0, -1);
      cnt = 0;
      for (int h = 142; h < 1600; h++) if (busy_at[h] !== 1'b0) cnt++;
      n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL idle_until_line_start busy_cycles=%0d expected=0", cnt); end
      run_line(10, 0, 1600, 0, -1);
      n_tests++; if (busy_at[0] !== 1'b1) begin n_fail++; $display("FAIL fill_after_reset busy=%b expected=1", busy_at[0]); end
   endtask

   task automatic test_tile_fetch();
      logic [15:0] w;
      fill_tmap(3);
      run_line(9, 0, 1600, 1, -1);
      run_line(10, 0, 1600, 1, -1);
      w = rom_word(12'h3A5);
      n_tests++;
      if ({got_r[75], got_g[75], got_b[75]} !== {w[15:11], 3'b000, w[10:5], 2'b00, w[4:0], 3'b000}) begin
         n_fail++;
         $display("FAIL line10_x37 got=%h_%h_%h word=%h", got_r[75], got_g[75], got_b[75], w);
      end
   endtask

   task automatic test_bg_tile();
      fill_tmap(-1);
      tmap[40] = 4'd0;
      tmap[79] = 4'd5;
      bg_rgb = 16'hF800;
      run_line(18, 0, 1600, 0, -1);
      run_line(19, 0, 1600, 0, -1);
      for (int h = 0; h <= 18; h++) begin
         n_tests++;
         if (rom_at[h] !== 12'h53F) begin n_fail++; $display("FAIL bg_rom_hold h=%0d got=%h expected=53f", h, rom_at[h]); end
      end
      run_line(20, 0, 1600, 1, -1);
      for (int x = 0; x < 16; x++) begin
         n_tests++;
         if ({got_r[2*x+1], got_g[2*x+1], got_b[2*x+1]} !== 24'hF80000) begin
            n_fail++;
            $display("FAIL bg_pixel x=%0d got=%h_%h_%h expected=f8_00_00", x, got_r[2*x+1], got_g[2*x+1], got_b[2*x+1]);
         end
      end
   endtask

   task automatic test_line0_wrap();
      int cnt;
      fill_tmap(-1);
      bg_rgb = 16'(($urandom));
      run_line(524, 0, 1600, 1, -1);
      for (int c = 0; c < 40; c++) begin
         n_tests++;
         if (tmap_at[19*c] !== 11'(c)) begin n_fail++; $display("FAIL line0_tmap col=%0d got=%0d expected=%0d", c, tmap_at[19*c], c); end
      end
      run_line(0, 0, 1600, 1, -1);
      run_line(478, 0, 1600, 1, -1);
      for (int c = 0; c < 40; c++) begin
         n_tests++;
         if (tmap_at[19*c] !== 11'(1160 + c)) begin n_fail++; $display("FAIL line479_tmap col=%0d got=%0d expected=%0d", c, tmap_at[19*c], 1160 + c); end
      end
      run_line(479, 0, 1600, 1, -1);
      cnt = 0;
      for (int h = 0; h < 1600; h++) if (busy_at[h] !== 1'b0) cnt++;
      n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL no_fill_line479 busy_cycles=%0d expected=0", cnt); end
   endtask

   task automatic test_overrun();
      fill_tmap(-1);
      run_line(30, 0, 700, 0, -1);
      n_tests++; if (ovr_at[699] !== 1'b0) begin n_fail++; $display("FAIL overrun_before got=%b expected=0", ovr_at[699]); end
      n_tests++; if (busy_at[699] !== 1'b1) begin n_fail++; $display("FAIL still_filling got=%b expected=1", busy_at[699]); end
      run_line(31, 0, 700, 0, 100);
      n_tests++; if (ovr_at[0] !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b expected=1", ovr_at[0]); end
      n_tests++; if (busy_at[0] !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b expected=1", busy_at[0]); end
      n_tests++; if (tmap_at[0] !== 11'd80) begin n_fail++; $display("FAIL restart_tmap got=%0d expected=80", tmap_at[0]); end
      n_tests++; if (ovr_at[99] !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b expected=1", ovr_at[99]); end
      n_tests++; if (ovr_at[100] !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b expected=0", ovr_at[100]); end
      run_line(32, 0, 700, 0, 0);
      n_tests++; if (ovr_at[0] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got=%b expected=1", ovr_at[0]); end
      run_line(33, 0, 700, 0, 50);
      n_tests++; if (ovr_at[50] !== 1'b0) begin n_fail++; $display("FAIL overrun_clear2 got=%b expected=0", ovr_at[50]); end
      run_line(34, 0, 1600, 0, 10);
      n_tests++; if (ovr_at[1599] !== 1'b0) begin n_fail++; $display("FAIL overrun_end got=%b expected=0", ovr_at[1599]); end
      n_tests++; if (busy_at[1599] !== 1'b0) begin n_fail++; $display("FAIL fill_done got=%b expected=0", busy_at[1599]); end
   endtask

   task automatic test_random_lines();
      fill_tmap(-1);
      for (int i = 0; i < 60; i++) tmap[$urandom_range(0, 1199)] = 4'd0;
      bg_rgb = 16'($urandom);
      run_line(99, 0, 1600, 0, -1);
      for (int v = 100; v < 104; v++) run_line(v, 0, 1600, 1, -1);
   endtask

   initial begin
      rom_salt = 16'($urandom);
      prev_ok = 1'b0; prev_h = 0; prev_v = 0; prev_blank = 1'b0;
      bank_line[0] = -1; bank_line[1] = -1;
      test_reset();
      test_reset_mid_stream();
      test_tile_fetch();
      test_bg_tile();
      test_line0_wrap();
      test_overrun();
      test_random_lines();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
